// File: rtl/key_led_pkg.sv
// key_led_pkg: shared encodings for the key-driven LED pattern engine.
// Mode codes, entry patterns for each mode and the top speed level.
package key_led_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_FLOW_L = 2'd1;
  localparam logic [1:0] MODE_FLOW_R = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic [3:0] PAT_OFF    = 4'b0000;
  localparam logic [3:0] PAT_FLOW_L = 4'b0001;
  localparam logic [3:0] PAT_FLOW_R = 4'b1000;
  localparam logic [3:0] PAT_BLINK  = 4'b1111;

  localparam logic [1:0] SPEED_MAX = 2'd3;

  // Pattern loaded when a mode is entered.
  function automatic logic [3:0] entry_pattern(input logic [1:0] m);
    logic [3:0] p;
    case (m)
      MODE_FLOW_L: p = PAT_FLOW_L;
      MODE_FLOW_R: p = PAT_FLOW_R;
      MODE_BLINK:  p = PAT_BLINK;
      default:     p = PAT_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/key_led_tick.sv
// key_led_tick: step-period generator. Period is BASE_TICK >> speed clocks;
// a one-cycle step pulse fires on the edge where the counter wraps.
// The counter holds while en is low and returns to 0 on clr.
module key_led_tick
  import key_led_pkg::*;
#(
  parameter int BASE_TICK = 25_000_000,
  parameter int CNT_W     = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic       en,
  input  logic       clr,
  output logic       step
);

  localparam logic [CNT_W-1:0] P0M1 = CNT_W'(BASE_TICK - 1);
  localparam logic [CNT_W-1:0] P1M1 = CNT_W'((BASE_TICK >> 1) - 1);
  localparam logic [CNT_W-1:0] P2M1 = CNT_W'((BASE_TICK >> 2) - 1);
  localparam logic [CNT_W-1:0] P3M1 = CNT_W'((BASE_TICK >> 3) - 1);

  if ((BASE_TICK < 8) || ((BASE_TICK % 8) != 0)) begin : g_bad_base
    $error("key_led_tick: BASE_TICK must be >= 8 and divisible by 8");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;

  // Terminal count for the current speed level.
  always_comb begin
    last = P0M1;
    case (speed)
      2'd1:    last = P1M1;
      2'd2:    last = P2M1;
      2'd3:    last = P3M1;
      default: last = P0M1;
    endcase
  end

  assign step = en && (cnt == last);

  // Period counter: clear wins, otherwise count while enabled and wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == last) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: 4-LED pattern engine driven by debounced one-hot key pulses.
// key[0] next mode, key[1] speed up, key[2] speed down, key[3] run/pause.
// Optional idle auto-off is enabled by defining KEY_LED_AUTO_OFF_EN.
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int BASE_TICK    = 25_000_000,
  parameter int CNT_W        = 25,
  parameter int IDLE_TIMEOUT = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_val,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       running
);

  if (IDLE_TIMEOUT < 2) begin : g_bad_idle
    $error("key_led_ctrl: IDLE_TIMEOUT must be >= 2");
  end

  logic [3:0] key;
  logic       step;
  logic       tick_en;
  logic       tick_clr;
  logic       timeout;

  // Lowest set key bit wins when several arrive together.
  always_comb begin
    key = 4'b0000;
    if      (key_val[0]) key = 4'b0001;
    else if (key_val[1]) key = 4'b0010;
    else if (key_val[2]) key = 4'b0100;
    else if (key_val[3]) key = 4'b1000;
  end

`ifdef KEY_LED_AUTO_OFF_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt;

  // Idle counter: any key restarts it, otherwise count up and stick at the end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (key_val != 4'b0000) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_LAST) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Timeout only when no key arrives on the same edge.
  always_comb begin
    timeout = (idle_cnt == IDLE_LAST) && (key == 4'b0000);
  end
`else
  // No idle tracking in this build.
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // Counter is frozen on any key edge so a pause stops at the current count
  // and a key always pre-empts the step on its edge.
  always_comb begin
    tick_en  = running && (mode != MODE_OFF) && (key == 4'b0000);
    tick_clr = key[0] || key[1] || key[2] || timeout;
  end

  key_led_tick #(
    .BASE_TICK (BASE_TICK),
    .CNT_W     (CNT_W)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .speed (speed),
    .en    (tick_en),
    .clr   (tick_clr),
    .step  (step)
  );

  // Mode/speed/run registers and pattern register; keys take priority over steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode    <= MODE_OFF;
      speed   <= '0;
      running <= 1'b1;
      led     <= PAT_OFF;
    end else if (key[0]) begin
      mode <= mode + 2'd1;
      led  <= entry_pattern(mode + 2'd1);
    end else if (key[1]) begin
      if (speed != SPEED_MAX) speed <= speed + 2'd1;
    end else if (key[2]) begin
      if (speed != 2'd0) speed <= speed - 2'd1;
    end else if (key[3]) begin
      running <= ~running;
    end else if (timeout) begin
      mode <= MODE_OFF;
      led  <= PAT_OFF;
    end else if (step) begin
      case (mode)
        MODE_FLOW_L: led <= {led[2:0], led[3]};
        MODE_FLOW_R: led <= {led[0], led[3:1]};
        MODE_BLINK:  led <= ~led;
        default:     led <= PAT_OFF;
      endcase
    end
  end

endmodule
